bf_rr_sched: RTL and testbench
==============================

// Module: bf_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one srdy/drdy consumer between N srdy/drdy producers.
//  Grants one input at a time, holds the grant for up to 'burst' beats, tags each beat
//  with the granted input index on p_addr, and presents it through a registered output stage.
//  Sits in front of any single-port bfnetwork sink: checker, memory port or egress link.
// PARAMETERS
//  inputs  4  number of requesting producers (>=2)
//  width   8  data width per beat
//  abits   2  width of p_addr; must be >= clog2(inputs); upper bits zero-padded
//  burst   4  max beats per grant before forced rotation (>=1)
// PORTS
//  clk      in   1             rising-edge clock
//  reset    in   1             asynchronous, active-low reset
//  c_srdy   in   inputs        per-input source ready
//  c_drdy   out  inputs        per-input dest ready (one-hot or zero)
//  c_data   in   inputs*width  input i occupies bits [i*width +: width]
//  p_srdy   out  1             output beat valid
//  p_drdy   in   1             downstream accepts beat
//  p_addr   out  abits         index of the input that sourced p_data
//  p_data   out  width         output beat
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, gnt=0, rr_ptr=0, beat_cnt=0, p_srdy=0,
//    p_addr=0, p_data=0, c_drdy=0. Reset mid-burst drops the held beat; no partial transfer.
//  - Transfer on any port = srdy & drdy on the same rising edge.
//  - FSM IDLE: c_drdy=0. If any c_srdy, gnt <= first requester found scanning
//    rr_ptr, rr_ptr+1, ... (mod inputs); beat_cnt <= 0; -> GRANT. One-cycle arbitration bubble.
//  - FSM GRANT: c_drdy[gnt] = !p_srdy | p_drdy (combinational from p_drdy); all other bits 0.
//    On input transfer: p_data <= c_data[gnt], p_addr <= gnt, p_srdy <= 1, beat_cnt++.
//    Exit to IDLE, rr_ptr <= (gnt+1) mod inputs, when either:
//      (a) input transfer with beat_cnt == burst-1; or
//      (b) c_srdy[gnt]==0, i.e. the requester withdrew.
//  - Output register: p_srdy clears on p_drdy when no new beat loads in the same cycle.
//    Simultaneous output drain + input load keeps p_srdy=1 with the new data (full rate).
//  - Latency: c_data -> p_data 1 cycle after the input transfer. Within a grant, throughput
//    is 1 beat/cycle. Peak is burst/(burst+1) beats/cycle with the rotation bubble.
//  - p_drdy held low: c_drdy[gnt] deasserts once p_srdy=1; no data lost, no overwrite.
//  - Fairness: a continuously requesting input waits at most (inputs-1)*(burst+1) cycles
//    plus output stall cycles. Single requester gets re-granted after each bubble.
//  - Outputs p_srdy/p_addr/p_data are flop outputs; output NBAs use `SDLIB_DELAY.
//  - Pointer wrap: rr_ptr and gnt wrap explicitly mod inputs; non-power-of-2 'inputs' is legal.
// STRUCTURE
//  - bf_defs.vh (shared include): `SDLIB_DELAY default, FSM encodings BF_ST_IDLE=1'b0,
//    BF_ST_GRANT=1'b1, and clog2 function.
//  - Sub-module bf_rr_pick: combinational rotating priority encoder
//    (req[inputs], ptr -> idx[abits], any). All state stays in bf_rr_sched.
// TESTING
//  1 Reset: hold reset=0 with c_srdy=all 1s -> p_srdy=0, c_drdy=0; release -> first grant to input 0.
//  2 Single input 2 sends seq 1..10, p_drdy=1 -> p_data 1..10 in order, p_addr=2,
//    1-cycle bubble after every 4th beat.
//  3 All 4 inputs always requesting, burst=4 -> p_addr pattern 0x4,1x4,2x4,3x4,0...;
//    each input's data stream stays strictly incrementing.
//  4 Input 1 drops c_srdy after 2 beats -> grant exits, rr_ptr=2, and the next grant goes
//    to the next requester above input 1.
//  5 p_drdy random 50% pattern with 3 inputs -> no lost or duplicated beats;
//    per-address beat counts match the sent counts.
//  6 Assert reset=0 mid-burst with p_srdy=1 -> p_srdy=0 immediately (async);
//    after release, arbitration restarts at input 0.

Source files
------------

// File: rtl/bf_rr_sched_pkg.sv
// Shared types and helpers for the round-robin scheduler.
// FSM state encoding and the ceiling-log2 helper used for counter widths.
package bf_rr_sched_pkg;

    typedef enum logic {
        BF_ST_IDLE  = 1'b0,
        BF_ST_GRANT = 1'b1
    } bf_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bf_rr_pick.sv
// Rotating priority encoder: first requester at or above the pointer, wrapping.
// Purely combinational; all arbitration state lives in the scheduler.
module bf_rr_pick
    import bf_rr_sched_pkg::*;
#(
    parameter int inputs = 4,
    parameter int abits  = 2
) (
    input  logic [inputs-1:0] i_req,
    input  logic [abits-1:0]  i_ptr,
    output logic [abits-1:0]  o_idx,
    output logic              o_any
);

    int w_best;
    int w_dist;

    // Smallest forward distance from the pointer wins.
    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_best = inputs;
        w_dist = 0;
        for (int j = 0; j < inputs; j++) begin
            w_dist = j - int'(i_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + inputs;
            end
            if (i_req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = abits'(j);
                o_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bf_rr_sched.sv
// Round-robin scheduler: N srdy/drdy producers onto one registered consumer port.
// Grant is held for up to 'burst' beats; each beat is tagged with its source index.
`ifndef SDLIB_DELAY
`define SDLIB_DELAY
`endif

module bf_rr_sched
    import bf_rr_sched_pkg::*;
#(
    parameter int inputs = 4,
    parameter int width  = 8,
    parameter int abits  = 2,
    parameter int burst  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [inputs-1:0]       c_srdy,
    output logic [inputs-1:0]       c_drdy,
    input  logic [inputs*width-1:0] c_data,
    output logic                    p_srdy,
    input  logic                    p_drdy,
    output logic [abits-1:0]        p_addr,
    output logic [width-1:0]        p_data
);

    localparam int              CW      = clog2(burst + 1);
    localparam logic [CW-1:0]    LASTBT  = CW'(burst - 1);
    localparam logic [abits-1:0] LASTIDX = abits'(inputs - 1);

    bf_state_e          r_state;
    bf_state_e          w_state_nxt;
    logic [abits-1:0]   r_gnt;
    logic [abits-1:0]   r_ptr;
    logic [CW-1:0]      r_cnt;
    logic               r_p_srdy;
    logic [abits-1:0]   r_p_addr;
    logic [width-1:0]   r_p_data;

    logic [abits-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_req_g;
    logic [width-1:0]   w_data_g;
    logic               w_out_free;
    logic               w_in_xfer;
    logic               w_exit;
    logic [abits-1:0]   w_gnt_inc;

    bf_rr_pick #(
        .inputs (inputs),
        .abits  (abits)
    ) u_pick (
        .i_req  (c_srdy),
        .i_ptr  (r_ptr),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    always_comb begin
        w_req_g  = 1'b0;
        w_data_g = '0;
        for (int i = 0; i < inputs; i++) begin
            if (r_gnt == abits'(i)) begin
                w_req_g  = c_srdy[i];
                w_data_g = c_data[i*width +: width];
            end
        end
    end

    assign w_out_free = !r_p_srdy || p_drdy;
    assign w_gnt_inc  = (r_gnt == LASTIDX) ? '0 : r_gnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        c_drdy      = '0;
        w_in_xfer   = 1'b0;
        w_exit      = 1'b0;
        unique case (r_state)
            BF_ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = BF_ST_GRANT;
                end
            end
            BF_ST_GRANT: begin
                for (int i = 0; i < inputs; i++) begin
                    c_drdy[i] = (r_gnt == abits'(i)) && w_out_free;
                end
                w_in_xfer = w_req_g && w_out_free;
                // Rotate on a full burst or as soon as the holder withdraws.
                w_exit = !w_req_g || (w_in_xfer && (r_cnt == LASTBT));
                if (w_exit) begin
                    w_state_nxt = BF_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = BF_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= BF_ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == BF_ST_IDLE) && w_pick_any) begin
                r_gnt <= w_pick_idx;
                r_cnt <= '0;
            end else if (w_in_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_exit) begin
                r_ptr <= w_gnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p_srdy <= `SDLIB_DELAY 1'b0;
            r_p_addr <= `SDLIB_DELAY '0;
            r_p_data <= `SDLIB_DELAY '0;
        end else if (w_in_xfer) begin
            r_p_srdy <= `SDLIB_DELAY 1'b1;
            r_p_addr <= `SDLIB_DELAY r_gnt;
            r_p_data <= `SDLIB_DELAY w_data_g;
        end else if (p_drdy) begin
            r_p_srdy <= `SDLIB_DELAY 1'b0;
        end
    end

    assign p_srdy = r_p_srdy;
    assign p_addr = r_p_addr;
    assign p_data = r_p_data;

endmodule

// File: tb/tb_bf_rr_sched.sv
// Self-checking bench for bf_rr_sched: cycle table plus scoreboarded random traffic.
// Producers emit known per-input sequences; outputs are matched per source index.
module tb_bf_rr_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AB = 2;
    localparam int BU = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   c_srdy;
    logic [N-1:0]   c_drdy;
    logic [N*W-1:0] c_data;
    logic           p_srdy;
    logic           p_drdy;
    logic [AB-1:0]  p_addr;
    logic [W-1:0]   p_data;

    bf_rr_sched #(
        .inputs (N),
        .width  (W),
        .abits  (AB),
        .burst  (BU)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .c_srdy (c_srdy),
        .c_drdy (c_drdy),
        .c_data (c_data),
        .p_srdy (p_srdy),
        .p_drdy (p_drdy),
        .p_addr (p_addr),
        .p_data (p_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       srdy;
        logic [7:0] data;
        logic [3:0] drdy;
        logic       ps;
        logic [7:0] pd;
    } vec_t;

    vec_t tv[15];
    int   ntv;

    int   errs;
    int   checks;
    int   sent[N];
    int   got[N];
    bit   en[N];
    int   lim[N];
    bit   pat_mode;
    int   beat_no;
    int   nout;
    int   last_addr;
    logic [N-1:0] last_drdy;

    function automatic logic [7:0] val(input int i, input int k);
        return 8'((i * 64 + k + 1) % 256);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int s, input int d, input int dr, input int ps, input int pd);
        tv[ntv].srdy = 1'(s);
        tv[ntv].data = 8'(d);
        tv[ntv].drdy = 4'(dr);
        tv[ntv].ps   = 1'(ps);
        tv[ntv].pd   = 8'(pd);
        ntv++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            c_srdy[i] = en[i] && (sent[i] < lim[i]);
            c_data[i*W +: W] = val(i, sent[i]);
        end
    endtask

    task automatic clear_model(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            sent[i] = 0;
            got[i]  = 0;
            en[i]   = mask[i];
            lim[i]  = 1000;
        end
        beat_no   = 0;
        nout      = 0;
        last_addr = -1;
    endtask

    // One clock: drive, sample mid-cycle, then account transfers at the edge.
    task automatic step();
        logic [N-1:0]  dr;
        logic [N-1:0]  sr;
        logic          ps;
        logic          pdr;
        logic [AB-1:0] pa;
        logic [W-1:0]  pd;
        bit            ok;
        drive();
        @(negedge clk);
        dr = c_drdy;
        sr = c_srdy;
        ps = p_srdy;
        pdr = p_drdy;
        pa = p_addr;
        pd = p_data;
        last_drdy = dr;
        ok = $onehot0(dr) && !(ps && !pdr && (dr != '0));
        chk("drdy_legal", int'(ok), 1);
        @(posedge clk);
        #1;
        if (ps && pdr) begin
            chk("beat_not_extra", int'(got[pa] < sent[pa]), 1);
            chk("beat_data", int'(pd), int'(val(int'(pa), got[pa])));
            if (pat_mode) begin
                chk("rr_pattern", int'(pa), (beat_no / BU) % N);
            end
            got[pa]++;
            beat_no++;
            nout++;
            last_addr = int'(pa);
        end
        for (int i = 0; i < N; i++) begin
            if (sr[i] && dr[i]) begin
                sent[i]++;
            end
        end
    endtask

    task automatic do_reset(input logic [N-1:0] mask);
        reset = 1'b0;
        p_drdy = 1'b1;
        clear_model(mask);
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_p_srdy", int'(p_srdy), 0);
        chk("rst_c_drdy", int'(c_drdy), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_out(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (nout < n && k < budget) begin
            step();
            k++;
        end
        if (nout < n) begin
            chk(name, 0, 1);
        end
    endtask

    initial begin
        errs = 0;
        checks = 0;
        ntv = 0;
        pat_mode = 1'b0;
        reset = 1'b0;
        p_drdy = 1'b1;
        c_srdy = '0;
        c_data = '0;

        // Test 1: reset with all requesting, first grant to input 0.
        do_reset(4'hF);
        chk("rst_p_addr", int'(p_addr), 0);
        step();
        chk("idle_drdy", int'(last_drdy), 0);
        step();
        chk("first_grant", int'(last_drdy), 1);
        wait_out(1, 10, "first_beat_timeout");
        chk("first_addr", last_addr, 0);

        // Test 2: single input 2, table of per-cycle expectations.
        add(1, 1, 0, 0, 0);
        add(1, 1, 4, 0, 0);
        add(1, 2, 4, 1, 1);
        add(1, 3, 4, 1, 2);
        add(1, 4, 4, 1, 3);
        add(1, 5, 0, 1, 4);
        add(1, 5, 4, 0, 0);
        add(1, 6, 4, 1, 5);
        add(1, 7, 4, 1, 6);
        add(1, 8, 4, 1, 7);
        add(1, 9, 0, 1, 8);
        add(1, 9, 4, 0, 0);
        add(1, 10, 4, 1, 9);
        add(0, 0, 4, 1, 10);
        add(0, 0, 0, 0, 0);
        do_reset(4'h0);
        for (int r = 0; r < ntv; r++) begin
            c_srdy = 4'(tv[r].srdy) << 2;
            c_data = 32'(tv[r].data) << 16;
            p_drdy = 1'b1;
            @(negedge clk);
            chk($sformatf("t2_drdy[%0d]", r), int'(c_drdy), int'(tv[r].drdy));
            chk($sformatf("t2_psrdy[%0d]", r), int'(p_srdy), int'(tv[r].ps));
            if (tv[r].ps) begin
                chk($sformatf("t2_pdata[%0d]", r), int'(p_data), int'(tv[r].pd));
                chk($sformatf("t2_paddr[%0d]", r), int'(p_addr), 2);
            end
            @(posedge clk);
            #1;
        end

        // Test 3: all inputs requesting, strict burst rotation.
        do_reset(4'hF);
        pat_mode = 1'b1;
        wait_out(32, 200, "t3_timeout");
        pat_mode = 1'b0;

        // Test 4: input 1 withdraws after 2 beats; next grant goes above it.
        do_reset(4'b0010);
        lim[1] = 2;
        for (int k = 0; k < 20 && sent[1] < 2; k++) begin
            step();
        end
        chk("t4_sent1", sent[1], 2);
        en[0] = 1'b1;
        en[3] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (last_addr >= 0 && last_addr != 1) break;
            step();
        end
        chk("t4_next_grant", last_addr, 3);
        chk("t4_got1", got[1], 2);

        // Test 5: random traffic and random backpressure on three inputs.
        do_reset(4'b0111);
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++) begin
                en[i] = ($urandom_range(0, 3) != 0);
            end
            p_drdy = 1'($urandom_range(0, 1));
            step();
        end
        for (int i = 0; i < N; i++) en[i] = 1'b0;
        p_drdy = 1'b1;
        repeat (6) step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t5_count[%0d]", i), got[i], sent[i]);
        end
        chk("t5_progress", int'(nout > 50), 1);

        // Test 6: asynchronous reset mid-burst while holding a beat.
        do_reset(4'hF);
        p_drdy = 1'b0;
        for (int k = 0; k < 10 && !p_srdy; k++) begin
            step();
        end
        chk("t6_held", int'(p_srdy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_psrdy", int'(p_srdy), 0);
        chk("t6_async_drdy", int'(c_drdy), 0);
        chk("t6_async_pdata", int'(p_data), 0);
        @(posedge clk);
        #1;
        clear_model(4'hF);
        p_drdy = 1'b1;
        drive();
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_out(1, 10, "t6_timeout");
        chk("t6_restart_addr", last_addr, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
